// File: rtl/dac_i2s_tx.sv
// I2S serialiser for the audio DAC: buffers {L,R} sample pairs in a small FIFO and shifts them out on bclk/lrck/sdata.
// Latency: a pushed pair leaves at the next frame boundary (one frame = 64*BCLK_DIV clk). All outputs are registered.
// Backpressure: smp_ready is low while the FIFO is full. Optional macro DAC_I2S_TX_HOLD_EN repeats the last frame on underrun.
module dac_i2s_tx #(
  parameter int BCLK_DIV = 2,
  parameter int FIFO_AW  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        smp_l,
  input  logic [15:0]        smp_r,
  input  logic               smp_valid,
  output logic               smp_ready,
  output logic               bclk,
  output logic               lrck,
  output logic               sdata,
  output logic               underrun,
  output logic [FIFO_AW:0]   fifo_level
);

  localparam int               DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [7:0]       CNT_MAX  = 8'(BCLK_DIV - 1);

  logic [7:0]         cnt_q, cnt_d;
  logic               bclk_q, bclk_d;
  logic               lrck_q, lrck_d;
  logic               sdata_q, sdata_d;
  logic               underrun_q, underrun_d;
  logic [4:0]         slot_q, slot_d;
  logic [31:0]        shreg_q, shreg_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ready_q, ready_d;
  logic [31:0]        mem_q [DEPTH];
  logic [31:0]        mem_d [DEPTH];
`ifdef DAC_I2S_TX_HOLD_EN
  logic [31:0]        last_q, last_d;
`endif

  logic        tick, fall, load, empty, push, pop;
  logic [31:0] fill;

  // Frame filler used when the FIFO is empty at a frame boundary.
`ifdef DAC_I2S_TX_HOLD_EN
  assign fill = last_q;
`else
  assign fill = 32'h0;
`endif

  // Bit-clock divider, slot counter and shift register; loads a frame when slot wraps 31->0.
  always_comb begin
    tick       = (cnt_q == CNT_MAX);
    fall       = tick && bclk_q;
    empty      = (level_q == '0);
    load       = fall && (slot_q == 5'd31);
    pop        = load && !empty;
    push       = smp_valid && ready_q;
    cnt_d      = tick ? 8'd0 : cnt_q + 8'd1;
    bclk_d     = tick ? ~bclk_q : bclk_q;
    slot_d     = slot_q;
    shreg_d    = shreg_q;
    sdata_d    = sdata_q;
    lrck_d     = lrck_q;
    underrun_d = load && empty;
    if (fall) begin
      slot_d = slot_q + 5'd1;
      if (load) begin
        shreg_d = empty ? fill : mem_q[rd_ptr_q];
      end else begin
        shreg_d = {shreg_q[30:0], 1'b0};
      end
      sdata_d = shreg_d[31];
      // lrck leads the MSB of each word by one bclk.
      lrck_d  = (slot_d >= 5'd15) && (slot_d <= 5'd30);
    end
  end

  // FIFO pointers, occupancy and storage; push/pop in the same clk leave the level unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {smp_l, smp_r};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    ready_d = (level_d != FULL_LVL);
  end

`ifdef DAC_I2S_TX_HOLD_EN
  // Remember the most recently popped frame for repeat-on-underrun.
  always_comb begin
    last_d = last_q;
    if (pop) last_d = mem_q[rd_ptr_q];
  end
`endif

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= 8'd0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      slot_q     <= 5'd31;
      shreg_q    <= 32'h0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
`ifdef DAC_I2S_TX_HOLD_EN
      last_q     <= 32'h0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      slot_q     <= slot_d;
      shreg_q    <= shreg_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
`ifdef DAC_I2S_TX_HOLD_EN
      last_q     <= last_d;
`endif
    end
  end

  // FIFO storage needs no reset; pointers define which entries are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign smp_ready  = ready_q;
  assign bclk       = bclk_q;
  assign lrck       = lrck_q;
  assign sdata      = sdata_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Bench for dac_i2s_tx: random and directed stimulus against a frame-level reference model.
// Main instance BCLK_DIV=2, FIFO_AW=2; idle instances with BCLK_DIV=1 and 5 check divider timing.
// Model derives bclk/slot from elapsed clk count and reads sdata as a bit of the current frame.
module tb_dac_i2s_tx;

  localparam int DIV   = 2;
  localparam int DEPTH = 4;
`ifdef DAC_I2S_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] smp_l = '0, smp_r = '0;
  logic        smp_valid = 1'b0;
  logic        smp_ready, bclk, lrck, sdata, underrun;
  logic [2:0]  fifo_level;
  logic        idle_vld = 1'b0;
  logic [15:0] idle_dat = '0;
  logic        rdy1, bclk1, lrck1, sdata1, ur1;
  logic [2:0]  lvl1;
  logic        rdy5, bclk5, lrck5, sdata5, ur5;
  logic [2:0]  lvl5;

  always #5 clk = ~clk;

  dac_i2s_tx #(.BCLK_DIV(DIV), .FIFO_AW(2)) u_dut (
    .clk(clk), .reset(reset), .smp_l(smp_l), .smp_r(smp_r), .smp_valid(smp_valid),
    .smp_ready(smp_ready), .bclk(bclk), .lrck(lrck), .sdata(sdata),
    .underrun(underrun), .fifo_level(fifo_level));

  dac_i2s_tx #(.BCLK_DIV(1), .FIFO_AW(2)) u_div1 (
    .clk(clk), .reset(reset), .smp_l(idle_dat), .smp_r(idle_dat), .smp_valid(idle_vld),
    .smp_ready(rdy1), .bclk(bclk1), .lrck(lrck1), .sdata(sdata1),
    .underrun(ur1), .fifo_level(lvl1));

  dac_i2s_tx #(.BCLK_DIV(5), .FIFO_AW(2)) u_div5 (
    .clk(clk), .reset(reset), .smp_l(idle_dat), .smp_r(idle_dat), .smp_valid(idle_vld),
    .smp_ready(rdy5), .bclk(bclk5), .lrck(lrck5), .sdata(sdata5),
    .underrun(ur5), .fifo_level(lvl5));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int          t = 0;
  logic [31:0] q[$];
  logic [31:0] cur = '0, last = '0;
  logic        m_lrck = 1'b0, m_sdata = 1'b0, m_ur = 1'b0;
  logic        in_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic bit bclk_at(int tt, int d);
    return ((tt / d) % 2) == 1;
  endfunction

  function automatic bit load_at(int tt, int d);
    return tt > 0 && (tt % d) == 0 && ((tt / d) % 2) == 0 && (((tt / d / 2) % 32) == 1);
  endfunction

  function automatic int slot_now();
    return ((t / (2 * DIV)) + 31) % 32;
  endfunction

  // One clk: drive inputs, advance the model across the edge, then compare.
  task automatic cyc(input logic vld, input logic [15:0] l, input logic [15:0] r, input logic rst);
    logic acc;
    int h, k, slot;
    reset = rst; smp_valid = vld; smp_l = l; smp_r = r;
    acc = vld && !rst && (q.size() != DEPTH);
    @(posedge clk);
    if (rst) begin
      t = 0; q.delete(); cur = '0; last = '0;
      m_lrck = 1'b0; m_sdata = 1'b0; m_ur = 1'b0; in_rst = 1'b1;
    end else begin
      in_rst = 1'b0;
      t++;
      m_ur = 1'b0;
      if (t % DIV == 0) begin
        h = t / DIV;
        if (h % 2 == 0) begin
          k = h / 2;
          slot = (k + 31) % 32;
          if (slot == 0) begin
            if (q.size() > 0) begin
              cur = q.pop_front();
              last = cur;
            end else begin
              cur = HOLD ? last : 32'h0;
              m_ur = 1'b1;
            end
          end
          m_sdata = cur[31 - slot];
          m_lrck  = (slot >= 15) && (slot <= 30);
        end
      end
      if (acc) q.push_back({l, r});
    end
    #1;
    chk("bclk",     32'(bclk),       in_rst ? 32'd0 : 32'(bclk_at(t, DIV)));
    chk("lrck",     32'(lrck),       32'(m_lrck));
    chk("sdata",    32'(sdata),      32'(m_sdata));
    chk("underrun", 32'(underrun),   32'(m_ur));
    chk("level",    32'(fifo_level), 32'(q.size()));
    chk("ready",    32'(smp_ready),  32'(q.size() != DEPTH));
    chk("bclk_div1", 32'(bclk1), in_rst ? 32'd0 : 32'(bclk_at(t, 1)));
    chk("ur_div1",   32'(ur1),   in_rst ? 32'd0 : 32'(load_at(t, 1)));
    chk("sdata_div1", 32'(sdata1), 32'd0);
    chk("bclk_div5", 32'(bclk5), in_rst ? 32'd0 : 32'(bclk_at(t, 5)));
    chk("ur_div5",   32'(ur5),   in_rst ? 32'd0 : 32'(load_at(t, 5)));
    chk("sdata_div5", 32'(sdata5), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b1);
  endtask

  localparam int FRAME = 64 * DIV;

  initial begin
    int guard;
    logic [15:0] cnt;
    int pct;

    // Reset values.
    do_reset(3);

    // Basic frame: one pair pushed before the first fall tick, then idle (second frame underruns).
    cyc(1'b1, 16'hA5F0, 16'h1234, 1'b0);
    idle(3 * FRAME);

    // Hold/underrun pattern: single pair then starve.
    do_reset(2);
    cyc(1'b1, 16'h7FFF, 16'h8001, 1'b0);
    idle(3 * FRAME);

    // Simultaneous push/pop at level 2.
    do_reset(2);
    cyc(1'b1, 16'h1111, 16'h2222, 1'b0);
    cyc(1'b1, 16'h3333, 16'h4444, 1'b0);
    guard = 0;
    while (!load_at(t + 1, DIV) && guard < 2 * FRAME) begin
      idle(1);
      guard++;
    end
    if (guard >= 2 * FRAME) chk("timeout_load", 32'd1, 32'd0);
    cyc(1'b1, 16'h5555, 16'h6666, 1'b0);
    chk("simul_level", 32'(fifo_level), 32'd2);
    idle(3 * FRAME);

    // Backpressure: valid held high with incrementing data.
    cnt = 16'h0100;
    for (int i = 0; i < 6 * FRAME; i++) begin
      if (smp_ready) cnt = cnt + 16'd1;
      cyc(1'b1, cnt, ~cnt, 1'b0);
    end
    idle(5 * FRAME);

    // Reset mid-frame at slot 20 with 3 entries queued.
    do_reset(2);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'hC000 + 16'(i), 16'h0C00 + 16'(i), 1'b0);
    guard = 0;
    while (!(t > 2 * DIV && slot_now() == 20) && guard < 2 * FRAME) begin
      idle(1);
      guard++;
    end
    if (guard >= 2 * FRAME) chk("timeout_slot", 32'd1, 32'd0);
    chk("pre_rst_level", 32'(fifo_level), 32'd3);
    do_reset(1);
    chk("mid_rst_bclk",  32'(bclk),       32'd0);
    chk("mid_rst_lrck",  32'(lrck),       32'd0);
    chk("mid_rst_sdata", 32'(sdata),      32'd0);
    chk("mid_rst_level", 32'(fifo_level), 32'd0);
    do_reset(1);
    idle(2 * FRAME);

    // Random traffic at several densities.
    for (int f = 0; f < 12; f++) begin
      pct = (f % 3 == 0) ? 10 : ((f % 3 == 1) ? 40 : 90);
      for (int i = 0; i < FRAME; i++)
        cyc(($urandom_range(0, 99) < pct), 16'($urandom), 16'($urandom), 1'b0);
    end
    idle(5 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
